// File: rtl/add_sub_pipe_pkg.sv
// Shared ALU definitions: op encoding, flag bundle and the signed-overflow rule.
package add_sub_pipe_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
   } flags_t;

   // Overflow when both addends share a sign and the sum's sign differs.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/add_sub_pipe_stage.sv
// One carry-chain segment: adds chunk IDX with the incoming carry and registers
// the carry-out, the partial result and the operands for the following stages.
module add_sub_stage #(
   parameter int WIDTH = 32,
   parameter int C     = 8,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] bp_i,
   input  logic [WIDTH-1:0] res_i,
   input  logic             cin_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] bp_o,
   output logic [WIDTH-1:0] res_o,
   output logic             cout_o
);

   logic [C:0]       sum_d;
   logic [WIDTH-1:0] res_d;
   logic             valid_q;
   logic             cout_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] bp_q;
   logic [WIDTH-1:0] res_q;

   always_comb begin
      sum_d = {1'b0, a_i[IDX*C +: C]} + {1'b0, bp_i[IDX*C +: C]} + {{C{1'b0}}, cin_i};
      res_d = res_i;
      res_d[IDX*C +: C] = sum_d[C-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         cout_q  <= 1'b0;
         a_q     <= '0;
         bp_q    <= '0;
         res_q   <= '0;
      end else if (en_i) begin
         valid_q <= valid_i;
         cout_q  <= sum_d[C];
         a_q     <= a_i;
         bp_q    <= bp_i;
         res_q   <= res_d;
      end
   end

   assign valid_o = valid_q;
   assign cout_o  = cout_q;
   assign a_o     = a_q;
   assign bp_o    = bp_q;
   assign res_o   = res_q;

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/subtract unit: CHUNKS carry-chain stages under one global stall,
// subtract done as A + ~B + 1 with the +1 entering as carry-in of chunk 0.
module add_sub_pipe
   import add_sub_pipe_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int CHUNKS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int C = WIDTH / CHUNKS;
   localparam int L = CHUNKS - 1;

   logic             stall;
   logic             v_q   [0:L];
   logic             c_q   [0:L];
   logic [WIDTH-1:0] a_q   [0:L];
   logic [WIDTH-1:0] bp_q  [0:L];
   logic [WIDTH-1:0] res_q [0:L];
   flags_t           flags;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   for (genvar k = 0; k < CHUNKS; k++) begin : g_stage
      logic             v_in;
      logic             c_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] bp_in;
      logic [WIDTH-1:0] res_in;

      if (k == 0) begin : g_head
         assign v_in   = in_valid;
         assign c_in   = (op == OP_SUB);
         assign a_in   = a;
         assign bp_in  = (op == OP_SUB) ? ~b : b;
         assign res_in = '0;
      end else begin : g_body
         assign v_in   = v_q[k-1];
         assign c_in   = c_q[k-1];
         assign a_in   = a_q[k-1];
         assign bp_in  = bp_q[k-1];
         assign res_in = res_q[k-1];
      end

      add_sub_stage #(.WIDTH(WIDTH), .C(C), .IDX(k)) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .en_i    (!stall),
         .valid_i (v_in),
         .a_i     (a_in),
         .bp_i    (bp_in),
         .res_i   (res_in),
         .cin_i   (c_in),
         .valid_o (v_q[k]),
         .a_o     (a_q[k]),
         .bp_o    (bp_q[k]),
         .res_o   (res_q[k]),
         .cout_o  (c_q[k])
      );
   end

   // zero is qualified by valid so the idle/reset value reads 0, not "result is zero".
   always_comb begin
      flags.carry    = c_q[L];
      flags.overflow = signed_ovf(a_q[L][WIDTH-1], bp_q[L][WIDTH-1], res_q[L][WIDTH-1]);
      flags.zero     = v_q[L] && (res_q[L] == '0);
   end

   assign out_valid = v_q[L];
   assign result    = res_q[L];
   assign carry     = flags.carry;
   assign overflow  = flags.overflow;
   assign zero      = flags.zero;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: directed 8-bit/2-stage cases plus a 32-bit/4-stage
// instance driven against a whole-result delay-line reference.
module tb_add_sub_pipe;
   import add_sub_pipe_pkg::*;

   typedef struct {
      logic        v;
      logic [31:0] r;
      logic        c;
      logic        ov;
      logic        z;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       iv8, ir8, op8, or8, ov8, c8, f8, z8;
   logic [7:0] a8, b8, r8;

   logic        iv32, ir32, op32, or32, ov32, c32, f32, z32;
   logic [31:0] a32, b32, r32;

   add_sub_pipe #(.WIDTH(8), .CHUNKS(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
      .out_valid(ov8), .out_ready(or8), .result(r8), .carry(c8), .overflow(f8), .zero(z8)
   );

   add_sub_pipe #(.WIDTH(32), .CHUNKS(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .op(op32),
      .out_valid(ov32), .out_ready(or32), .result(r32), .carry(c32), .overflow(f32), .zero(z32)
   );

   int checks = 0;
   int failures = 0;
   int acc_total = 0;
   int emit_obs = 0;
   logic acc_flag;
   logic [31:0] last_r;
   logic last_c, last_ov, last_z;
   ent_t pipe [0:3];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t ref32(input logic [31:0] a, input logic [31:0] b, input logic op);
      ent_t e;
      longint sa, sb, v;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      e.v = 1'b1;
      if (op) begin
         v = sa - sb;
         e.r = a - b;
         e.c = (ua >= ub);
      end else begin
         v = sa + sb;
         e.r = a + b;
         e.c = (ua + ub) > 64'hFFFF_FFFF;
      end
      e.ov = (v > 64'sd2147483647) || (v < -64'sd2147483648);
      e.z = (e.r == 32'd0);
      return e;
   endfunction

   // One clock of the 32-bit instance: drive, compare against the model, advance the model.
   task automatic step32(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic ordy, input logic rstn);
      ent_t e;
      logic stall;
      @(negedge clk);
      rst_n = rstn;
      iv32 = iv; a32 = a; b32 = b; op32 = op; or32 = ordy;
      #1;
      e = pipe[3];
      check("out_valid32", ov32, e.v);
      stall = e.v && !ordy;
      check("in_ready32", ir32, !stall);
      if (e.v) begin
         check("result32", r32, e.r);
         check("carry32", c32, e.c);
         check("overflow32", f32, e.ov);
         check("zero32", z32, e.z);
      end
      if (ov32 === 1'b1 && ordy) begin
         emit_obs++;
         last_r = r32; last_c = c32; last_ov = f32; last_z = z32;
      end
      acc_flag = 1'b0;
      if (!rstn) begin
         for (int i = 0; i < 4; i++) pipe[i].v = 1'b0;
      end else if (!stall) begin
         for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = ref32(a, b, op);
         pipe[0].v = iv;
         acc_flag = iv;
         if (iv) acc_total++;
      end
   endtask

   task automatic beat8(input logic [7:0] a, input logic [7:0] b, input logic op, input string tag,
                        input logic [7:0] er, input logic ec, input logic eo, input logic ez);
      @(negedge clk);
      iv8 = 1'b1; a8 = a; b8 = b; op8 = op; or8 = 1'b1;
      #1 check({tag, "_in_ready"}, ir8, 1'b1);
      @(negedge clk);
      iv8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
      #1 check({tag, "_early"}, ov8, 1'b0);
      @(negedge clk);
      #1;
      check({tag, "_valid"}, ov8, 1'b1);
      check({tag, "_result"}, r8, er);
      check({tag, "_carry"}, c8, ec);
      check({tag, "_overflow"}, f8, eo);
      check({tag, "_zero"}, z8, ez);
      @(negedge clk);
      #1 check({tag, "_single"}, ov8, 1'b0);
   endtask

   initial begin
      int sent, n, em0, stall_acc;
      rst_n = 1'b0;
      iv8 = 0; a8 = 0; b8 = 0; op8 = 0; or8 = 1;
      iv32 = 0; a32 = 0; b32 = 0; op32 = 0; or32 = 1;
      for (int i = 0; i < 4; i++) pipe[i] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid8", ov8, 1'b0);
      check("rst_result8", r8, 8'h00);
      check("rst_flags8", {c8, f8, z8}, 3'b000);
      check("rst_ready8", ir8, 1'b1);
      check("rst_valid32", ov32, 1'b0);
      check("rst_result32", r32, 32'd0);
      check("rst_flags32", {c32, f32, z32}, 3'b000);
      check("rst_ready32", ir32, 1'b1);
      rst_n = 1'b1;

      beat8(8'hFF, 8'h01, OP_ADD, "add_ff_01", 8'h00, 1'b1, 1'b0, 1'b1);
      beat8(8'h7F, 8'h01, OP_ADD, "add_7f_01", 8'h80, 1'b0, 1'b1, 1'b0);
      beat8(8'h80, 8'h01, OP_SUB, "sub_80_01", 8'h7F, 1'b1, 1'b1, 1'b0);

      step32(1'b1, 32'd5, 32'd7, OP_SUB, 1'b1, 1'b1);
      repeat (5) step32(1'b0, 32'd0, 32'd0, OP_ADD, 1'b1, 1'b1);
      check("sub5_7_result", last_r, 32'hFFFF_FFFE);
      check("sub5_7_flags", {last_c, last_ov, last_z}, 3'b000);
      step32(1'b1, 32'd7, 32'd7, OP_SUB, 1'b1, 1'b1);
      repeat (5) step32(1'b0, 32'd0, 32'd0, OP_ADD, 1'b1, 1'b1);
      check("sub7_7_result", last_r, 32'd0);
      check("sub7_7_flags", {last_c, last_ov, last_z}, 3'b101);

      sent = 0;
      n = 0;
      while (n < 300 && sent < 16) begin
         step32(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
         if (acc_flag) sent++;
         n++;
      end
      check("stream_sent", sent, 16);
      repeat (8) step32(1'b0, 32'd0, 32'd0, OP_ADD, 1'b1, 1'b1);
      check("stream_count", emit_obs, acc_total);

      repeat (4) step32(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      stall_acc = 0;
      repeat (5) begin
         step32(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
         if (ir32 === 1'b1) stall_acc++;
      end
      check("stall_no_accept", stall_acc, 0);
      em0 = emit_obs;
      repeat (4) step32(1'b0, 32'd0, 32'd0, OP_ADD, 1'b1, 1'b1);
      check("drain_four", emit_obs - em0, 4);
      step32(1'b0, 32'd0, 32'd0, OP_ADD, 1'b1, 1'b1);

      repeat (3) step32(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      step32(1'b1, $urandom, $urandom, OP_ADD, 1'b1, 1'b0);
      step32(1'b0, 32'd0, 32'd0, OP_ADD, 1'b1, 1'b1);
      check("midrst_valid", ov32, 1'b0);
      check("midrst_result", r32, 32'd0);
      check("midrst_flags", {c32, f32, z32}, 3'b000);
      check("midrst_ready", ir32, 1'b1);
      em0 = emit_obs;
      repeat (6) step32(1'b0, 32'd0, 32'd0, OP_ADD, 1'b1, 1'b1);
      check("midrst_discard", emit_obs - em0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
